ultrasonic_ranger: RTL and testbench
====================================

# ultrasonic_ranger

Multi-channel, parametrised ultrasonic range-finder controller for HC-SR04-class sensors on the PMOD-D connector. It scans N_CH sensors round-robin, one channel at a time, so that sensors cannot hear each other's echoes. For each channel it fires a trigger pulse, measures the echo width in microseconds with a timeout, and emits a one-cycle result strobe. It also keeps a per-channel obstacle flag with threshold and hysteresis. It sits between the PMOD pins and the SoC register/interrupt logic, and replaces the single-channel fixed-threshold detector.

## Interface
- CLK_HZ, 64_000_000: clk frequency. CLK_HZ/1_000_000 must be an integer; this ratio is called US_DIV.
- N_CH, 4: number of sensor channels (1..8).
- TRIG_US, 10: trigger high time in µs.
- ECHO_MAX_US, 30000: timeout for echo rise and for echo width.
- HOLDOFF_US, 10000: quiet time after each measurement before the next channel starts.
- HYST_US, 100: hysteresis added to the threshold when clearing a near flag.
- W, $clog2(ECHO_MAX_US+1): result width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high, clock clk.
- enable  in  1  scan enable.
- thresh_us  in  W  near threshold in µs, shared by all channels.
- echo  in  N_CH  raw echo pins, asynchronous.
- trigger  out  N_CH  trigger pins, registered.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  $clog2(N_CH) (min 1)  channel of the result.
- res_us  out  W  echo width in µs.
- res_timeout  out  1  result is a timeout.
- near  out  N_CH  per-channel obstacle flags.
- busy  out  1  FSM not in IDLE.

## Operation
- Each echo bit passes through a 2-FF synchronizer. A rising/falling edge is detected on the synchronized value against its 1-cycle-delayed copy.
- µs prescaler: a counter 0..US_DIV-1 that is cleared on every FSM state change. A tick fires when the counter equals US_DIV-1.
- FSM states and transitions:
  - IDLE: if enable=1, go to TRIG with the current channel index ch.
  - TRIG: trigger[ch]=1; after TRIG_US ticks, go to WAIT_RISE.
  - WAIT_RISE: a synchronized rise of echo[ch] goes to MEASURE. If ECHO_MAX_US ticks pass with no rise, issue a timeout result and go to HOLDOFF. An echo already high on entry does not count as a rise; it must fall and rise again.
  - MEASURE: count ticks in width_cnt. A synchronized fall issues a result with res_us=width_cnt and res_timeout=0, then goes to HOLDOFF. If width_cnt reaches ECHO_MAX_US, issue a result with res_us=ECHO_MAX_US and res_timeout=1, then go to HOLDOFF.
  - HOLDOFF: after HOLDOFF_US ticks, ch advances (N_CH-1 wraps to 0), then go to IDLE. IDLE re-enters TRIG on the next cycle if enable is still 1.
- enable is sampled only in IDLE. Deasserting it mid-scan lets the current channel finish through HOLDOFF.
- Only trigger[ch] can be high, and only in TRIG. At most one trigger bit is ever high.
- near[ch] update rule, applied on the same edge as res_valid:
  - Timeout: clear.
  - Set when res_us < thresh_us.
  - Clear when res_us >= thresh_us + HYST_US. The sum is computed at W+1 bits with no wrap.
  - Otherwise hold.
- All comparisons are unsigned. width_cnt saturates; it never wraps.

## Timing
- Reset values: trigger=0, res_valid=0, res_ch=0, res_us=0, res_timeout=0, near=0, busy=0, state=IDLE, ch=0.
- Reset mid-operation drops trigger on the first clk edge with rst=1. No result is emitted.
- enable=1 in IDLE: trigger rises 2 edges later (IDLE→TRIG transition, then registered output). The trigger is high for exactly TRIG_US*US_DIV cycles.
- Echo latency is 2-FF sync plus 1 edge detect, so 3 cycles. The same delay applies to rise and fall, so the measured width equals floor(echo_high_cycles/US_DIV).
- res_valid is high for 1 cycle. There is no backpressure; the consumer must capture it. res_ch, res_us and res_timeout hold their values until the next strobe.
- Per-channel slot = TRIG + rise wait + width + HOLDOFF + 2 cycles of FSM overhead.
- If rise and timeout occur on the same cycle in WAIT_RISE, the rise wins. If fall and saturation occur on the same cycle in MEASURE, the fall wins with res_us=ECHO_MAX_US and res_timeout=0.

## Test plan
- Defaults, enable=1. Drive echo[0] high 200 µs after the trigger falls, for 580*64 cycles → res_valid with res_ch=0, res_us=580, res_timeout=0. Trigger is high for 640 cycles.
- echo[1] never rises → res_ch=1, res_us=30000, res_timeout=1, near[1]=0. HOLDOFF then passes and ch advances to 2.
- thresh_us=1000. Channel 2 echoes 900 → near[2]=1. Then 1050 → near[2] stays 1. Then 1100 → near[2]=0.
- echo[3] held high for 40 ms → timeout result with res_us=30000. ch then wraps to 0, and no trigger bit overlaps another.
- rst asserted during MEASURE → trigger=0, no res_valid, all outputs at reset values. After rst is released with enable=1, the scan restarts at ch=0.
- enable dropped during TRIG of ch 1 → the ch 1 result is still emitted, busy falls after HOLDOFF, and no further trigger fires.

Source files
------------

// File: rtl/ultrasonic_ranger.sv
// Round-robin HC-SR04-class range finder: triggers one sensor at a time, times its echo
// in microseconds with a timeout, and keeps a per-channel near flag with hysteresis.
module ultrasonic_ranger #(
  parameter int CLK_HZ      = 64_000_000,
  parameter int N_CH        = 4,
  parameter int TRIG_US     = 10,
  parameter int ECHO_MAX_US = 30000,
  parameter int HOLDOFF_US  = 10000,
  parameter int HYST_US     = 100,
  parameter int W           = $clog2(ECHO_MAX_US + 1),
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [W-1:0]    thresh_us,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] trigger,
  output logic            res_valid,
  output logic [CH_W-1:0] res_ch,
  output logic [W-1:0]    res_us,
  output logic            res_timeout,
  output logic [N_CH-1:0] near,
  output logic            busy
);

  localparam int US_DIV = CLK_HZ / 1_000_000;
  localparam int PW     = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int T_A    = (TRIG_US > HOLDOFF_US) ? TRIG_US : HOLDOFF_US;
  localparam int T_MAX  = (T_A > ECHO_MAX_US) ? T_A : ECHO_MAX_US;
  localparam int TW     = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t          state;
  logic [CH_W-1:0] ch;
  logic [PW-1:0]   pre;
  logic [TW-1:0]   tcnt;
  logic [W-1:0]    width_cnt;
  logic [W-1:0]    width_next;
  logic [N_CH-1:0] echo_p0, echo_p1, echo_p2;
  logic [N_CH-1:0] rise, fall;
  logic            tick;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic inc);
    if (inc && (v != W'(ECHO_MAX_US))) return v + W'(1);
    return v;
  endfunction

  function automatic logic near_upd(input logic cur, input logic [W-1:0] us,
                                    input logic tmo, input logic [W-1:0] thr);
    logic [W:0] clr_lvl;
    clr_lvl = {1'b0, thr} + (W+1)'(HYST_US);
    if (tmo) return 1'b0;
    if (us < thr) return 1'b1;
    if ({1'b0, us} >= clr_lvl) return 1'b0;
    return cur;
  endfunction

  // stage p0/p1: two-flop synchronizer; p2: delayed copy for edge detection
  always_ff @(posedge clk) begin
    echo_p0 <= echo;
    echo_p1 <= echo_p0;
    echo_p2 <= echo_p1;
  end

  assign rise       = echo_p1 & ~echo_p2;
  assign fall       = ~echo_p1 & echo_p2;
  assign tick       = (pre == PW'(US_DIV - 1));
  assign width_next = sat_inc(width_cnt, tick);

  // Prescaler and tick counter restart on every state change so each phase starts on a clean us boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= '0;
      pre         <= '0;
      tcnt        <= '0;
      width_cnt   <= '0;
      trigger     <= '0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_us      <= '0;
      res_timeout <= 1'b0;
      near        <= '0;
      busy        <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      trigger   <= (state == TRIG) ? (N_CH'(1) << ch) : '0;
      if (tick) begin
        pre  <= '0;
        tcnt <= tcnt + TW'(1);
      end else begin
        pre  <= pre + PW'(1);
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state <= TRIG;
            busy  <= 1'b1;
            pre   <= '0;
            tcnt  <= '0;
          end
        end
        TRIG: begin
          if (tick && (tcnt == TW'(TRIG_US - 1))) begin
            state <= WAIT_RISE;
            pre   <= '0;
            tcnt  <= '0;
          end
        end
        WAIT_RISE: begin
          if (rise[ch]) begin
            state     <= MEASURE;
            pre       <= '0;
            tcnt      <= '0;
            width_cnt <= '0;
          end else if (tick && (tcnt == TW'(ECHO_MAX_US - 1))) begin
            state       <= HOLDOFF;
            pre         <= '0;
            tcnt        <= '0;
            res_valid   <= 1'b1;
            res_ch      <= ch;
            res_us      <= W'(ECHO_MAX_US);
            res_timeout <= 1'b1;
            near[ch]    <= 1'b0;
          end
        end
        MEASURE: begin
          width_cnt <= width_next;
          // A fall on the saturating cycle still counts as a valid measurement.
          if (fall[ch] || (width_next == W'(ECHO_MAX_US))) begin
            state       <= HOLDOFF;
            pre         <= '0;
            tcnt        <= '0;
            res_valid   <= 1'b1;
            res_ch      <= ch;
            res_us      <= width_next;
            res_timeout <= ~fall[ch];
            near[ch]    <= near_upd(near[ch], width_next, ~fall[ch], thresh_us);
          end
        end
        HOLDOFF: begin
          if (tick && (tcnt == TW'(HOLDOFF_US - 1))) begin
            state <= IDLE;
            busy  <= 1'b0;
            pre   <= '0;
            tcnt  <= '0;
            ch    <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with a 4 MHz clock (4 cycles per us) and shortened
// timings so a full scan of several rounds stays short.
module tb_ultrasonic_ranger;

  localparam int W    = 8;
  localparam int N_CH = 4;
  localparam int NV   = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [W-1:0]    thresh_us;
  logic [N_CH-1:0] echo;
  logic [N_CH-1:0] trigger;
  logic            res_valid;
  logic [1:0]      res_ch;
  logic [W-1:0]    res_us;
  logic            res_timeout;
  logic [N_CH-1:0] near;
  logic            busy;

  ultrasonic_ranger #(
    .CLK_HZ(4_000_000), .N_CH(N_CH), .TRIG_US(3), .ECHO_MAX_US(200),
    .HOLDOFF_US(20), .HYST_US(10)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .thresh_us(thresh_us), .echo(echo),
    .trigger(trigger), .res_valid(res_valid), .res_ch(res_ch), .res_us(res_us),
    .res_timeout(res_timeout), .near(near), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch; int early; int dly; int high; int thr;
    int exp_us; int exp_to; logic [3:0] exp_near;
  } vec_t;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;
  int got_cnt = 0;
  int exp_cnt = 0;
  int overlap = 0;
  int trig_rises = 0;
  logic [1:0]      got_ch;
  logic [W-1:0]    got_us;
  logic            got_to;
  logic [N_CH-1:0] got_near;
  logic [N_CH-1:0] trig_prev = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid) begin
      got_cnt  <= got_cnt + 1;
      got_ch   <= res_ch;
      got_us   <= res_us;
      got_to   <= res_timeout;
      got_near <= near;
    end
    if (!$onehot0(trigger)) overlap <= overlap + 1;
    if (trigger != 0 && trig_prev == 0) trig_rises <= trig_rises + 1;
    trig_prev <= trigger;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, tw, r0;
    // ch, early, dly, high, thr, exp_us, exp_to, exp_near
    tbl[0]  = '{0,  0, 20, 232,  50,  58, 0, 4'b0000};
    tbl[1]  = '{1,  0,  0,   0,  50, 200, 1, 4'b0000};
    tbl[2]  = '{2,  0,  5, 360, 100,  90, 0, 4'b0100};
    tbl[3]  = '{3,  0,  5, 850, 100, 200, 1, 4'b0100};
    tbl[4]  = '{0,  0,  3, 120, 100,  30, 0, 4'b0101};
    tbl[5]  = '{1, 40, 10,   7, 100,   1, 0, 4'b0111};
    tbl[6]  = '{2,  0,  3, 420, 100, 105, 0, 4'b0111};
    tbl[7]  = '{3,  0,  3,   3, 100,   0, 0, 4'b1111};
    tbl[8]  = '{0,  0,  0,   0, 100, 200, 1, 4'b1110};
    tbl[9]  = '{1,  0,  8, 436, 100, 109, 0, 4'b1110};
    tbl[10] = '{2,  0,  8, 440, 100, 110, 0, 4'b1010};
    tbl[11] = '{3,  0,  2, 799, 100, 199, 0, 4'b0010};
    tbl[12] = '{0,  0,  2, 800, 100, 200, 0, 4'b0010};

    rst = 1'b1; enable = 1'b0; echo = '0; thresh_us = 8'd50;
    repeat (3) @(negedge clk);
    check("rst_trigger", trigger, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_ch", res_ch, 0);
    check("rst_res_us", res_us, 0);
    check("rst_res_to", res_timeout, 0);
    check("rst_near", near, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_trigger", trigger, 0);

    enable = 1'b1;
    @(negedge clk);
    check("trig_lat1", trigger, 0);
    check("busy_rise", busy, 1);
    @(negedge clk);
    check("trig_lat2", trigger, 4'b0001);

    for (int i = 0; i < NV; i++) begin
      thresh_us = 8'(tbl[i].thr);
      n = 0;
      while (trigger == 0 && n < 3000) begin @(negedge clk); n++; end
      check("trig_ch", trigger, 4'b0001 << tbl[i].ch);
      if (tbl[i].early > 0) echo[tbl[i].ch] = 1'b1;
      k = 0; tw = 0;
      while ((trigger != 0 || k < tbl[i].early) && k < 3000) begin
        if (trigger != 0) tw++;
        @(negedge clk);
        k++;
        if (k == tbl[i].early) echo[tbl[i].ch] = 1'b0;
      end
      check("trig_width", tw, 12);
      repeat (tbl[i].dly) @(negedge clk);
      if (tbl[i].high > 0) begin
        echo[tbl[i].ch] = 1'b1;
        repeat (tbl[i].high) @(negedge clk);
        echo[tbl[i].ch] = 1'b0;
      end
      exp_cnt++;
      n = 0;
      while (got_cnt < exp_cnt && n < 3000) begin @(negedge clk); n++; end
      check("res_cnt", got_cnt, exp_cnt);
      check("res_ch", got_ch, tbl[i].ch);
      check("res_us", got_us, tbl[i].exp_us);
      check("res_to", got_to, tbl[i].exp_to);
      check("near", got_near, tbl[i].exp_near);
    end

    // reset while channel 1 is measuring
    n = 0;
    while (trigger == 0 && n < 3000) begin @(negedge clk); n++; end
    check("mr_trig_ch", trigger, 4'b0010);
    n = 0;
    while (trigger != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    echo[1] = 1'b1;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_trigger", trigger, 0);
    check("mr_res_valid", res_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_near", near, 0);
    check("mr_res_us", res_us, 0);
    check("mr_res_ch", res_ch, 0);
    check("mr_res_to", res_timeout, 0);
    echo[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (trigger == 0 && n < 100) begin @(negedge clk); n++; end
    check("restart_ch", trigger, 4'b0001);
    check("restart_lat", n, 2);
    check("mr_no_res", got_cnt, exp_cnt);
    exp_cnt++;
    n = 0;
    while (got_cnt < exp_cnt && n < 3000) begin @(negedge clk); n++; end
    check("rs_res_cnt", got_cnt, exp_cnt);
    check("rs_res_ch", got_ch, 0);
    check("rs_res_us", got_us, 200);
    check("rs_res_to", got_to, 1);

    // enable dropped while channel 1 is triggering
    n = 0;
    while (trigger == 0 && n < 3000) begin @(negedge clk); n++; end
    check("en_trig_ch", trigger, 4'b0010);
    enable = 1'b0;
    exp_cnt++;
    n = 0;
    while (got_cnt < exp_cnt && n < 3000) begin @(negedge clk); n++; end
    check("en_res_cnt", got_cnt, exp_cnt);
    check("en_res_ch", got_ch, 1);
    check("en_res_to", got_to, 1);
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    check("en_busy_fall", busy, 0);
    r0 = trig_rises;
    repeat (400) @(negedge clk);
    check("en_no_trig", trig_rises, r0);
    check("en_no_res", got_cnt, exp_cnt);

    // resume picks up at channel 2; reset during trigger drops it at once
    enable = 1'b1;
    n = 0;
    while (trigger == 0 && n < 100) begin @(negedge clk); n++; end
    check("resume_ch", trigger, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    check("rt_trigger", trigger, 0);
    check("rt_busy", busy, 0);
    enable = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
